// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 device-to-host receiver with parity/framing/timeout checks
//            feeding a first-word-fall-through FIFO.
// Revision : 1.0
// ============================================================================
module ps2_rx_fifo #(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MSB_FIRST      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clear_err,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_BCNT_W = $clog2(DATA_BITS + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    state_t                 r_state;
    logic [c_BCNT_W-1:0]    r_bcnt;
    logic [c_TO_W-1:0]      r_tcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]    r_wptr;
    logic [c_ADDR_W-1:0]    r_rptr;
    logic [c_ADDR_W:0]      r_count;

    logic w_fall;
    logic w_bit;
    logic w_timeout;
    logic w_stop_fall;
    logic w_par_ok;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_set_ferr;
    logic w_set_perr;
    logic w_set_ovf;

    // Both lines use identical synchroniser depth so sampled data stays
    // aligned with the detected clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall      = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit       = r_data_sync[SYNC_STAGES-1];
    assign w_timeout   = (r_state != S_IDLE) && (r_tcnt == c_TO_W'(TIMEOUT_CYCLES));
    assign w_stop_fall = (r_state == S_STOP) && w_fall && !w_timeout;
    assign w_par_ok    = ^{r_shift, r_parity};
    assign w_full      = (r_count == (c_ADDR_W + 1)'(FIFO_DEPTH));
    assign w_pop       = rd_en && valid;
    assign w_set_ferr  = w_timeout || (w_stop_fall && !w_bit);
    assign w_set_perr  = w_stop_fall && w_bit && !w_par_ok;
    assign w_push      = w_stop_fall && w_bit && w_par_ok && (!w_full || w_pop);
    assign w_set_ovf   = w_stop_fall && w_bit && w_par_ok && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bcnt     <= '0;
            r_tcnt     <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_fall || w_timeout || r_state == S_IDLE) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_timeout) begin
                r_state <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_bit) begin
                            r_state <= S_DATA;
                            r_bcnt  <= '0;
                        end
                    end
                    S_DATA: begin
                        if (MSB_FIRST != 0) begin
                            r_shift <= {r_shift[DATA_BITS-2:0], w_bit};
                        end else begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_bcnt == c_BCNT_W'(DATA_BITS - 1)) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= S_STOP;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // A new error event wins over a simultaneous clear request.
            if (w_set_perr)     parity_err <= 1'b1;
            else if (clear_err) parity_err <= 1'b0;
            if (w_set_ferr)     frame_err  <= 1'b1;
            else if (clear_err) frame_err  <= 1'b0;
            if (w_set_ovf)      overflow   <= 1'b1;
            else if (clear_err) overflow   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid    = (r_count != '0);
    assign count    = r_count;
    assign data_out = valid ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed scoreboard bench for ps2_rx_fifo across four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst;
    logic ps2c;
    logic ps2d;
    logic rd_en;
    logic clear_err;
    int   sel;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] sb[$];

    logic [7:0] dout0, dout1, dout2;
    logic [8:0] dout3;
    logic [3:0] vld;
    logic [2:0] cnt [4];
    logic [3:0] perr, ferr, ovf;

    logic [8:0] m_dout;
    logic       m_valid;
    logic [2:0] m_count;
    logic [2:0] m_flags;

    always #5 clk = ~clk;

    ps2_rx_fifo u_def (
        .clk(clk), .rst(rst),
        .ps2_clk(sel == 0 ? ps2c : 1'b1), .ps2_data(sel == 0 ? ps2d : 1'b1),
        .rd_en(rd_en && sel == 0), .clear_err(clear_err && sel == 0),
        .data_out(dout0), .valid(vld[0]), .count(cnt[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overflow(ovf[0])
    );

    ps2_rx_fifo #(.TIMEOUT_CYCLES(100)) u_to (
        .clk(clk), .rst(rst),
        .ps2_clk(sel == 1 ? ps2c : 1'b1), .ps2_data(sel == 1 ? ps2d : 1'b1),
        .rd_en(rd_en && sel == 1), .clear_err(clear_err && sel == 1),
        .data_out(dout1), .valid(vld[1]), .count(cnt[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overflow(ovf[1])
    );

    ps2_rx_fifo #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst),
        .ps2_clk(sel == 2 ? ps2c : 1'b1), .ps2_data(sel == 2 ? ps2d : 1'b1),
        .rd_en(rd_en && sel == 2), .clear_err(clear_err && sel == 2),
        .data_out(dout2), .valid(vld[2]), .count(cnt[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overflow(ovf[2])
    );

    ps2_rx_fifo #(.DATA_BITS(9)) u_9 (
        .clk(clk), .rst(rst),
        .ps2_clk(sel == 3 ? ps2c : 1'b1), .ps2_data(sel == 3 ? ps2d : 1'b1),
        .rd_en(rd_en && sel == 3), .clear_err(clear_err && sel == 3),
        .data_out(dout3), .valid(vld[3]), .count(cnt[3]),
        .parity_err(perr[3]), .frame_err(ferr[3]), .overflow(ovf[3])
    );

    always_comb begin
        m_dout  = '0;
        m_valid = 1'b0;
        m_count = '0;
        m_flags = '0;
        case (sel)
            0: m_dout = {1'b0, dout0};
            1: m_dout = {1'b0, dout1};
            2: m_dout = {1'b0, dout2};
            default: m_dout = dout3;
        endcase
        if (sel >= 0 && sel < 4) begin
            m_valid = vld[sel];
            m_count = cnt[sel];
            m_flags = {perr[sel], ferr[sel], ovf[sel]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives frame bits [first..last]; optionally pops during the stop-bit fall cycle.
    task automatic send_frame(input logic [8:0] val, input int nb, input bit msb,
                              input int par, input bit stopb, input int first,
                              input int last, input bit pop_at_stop);
        bit seq[12];
        bit p;
        p = 1'b1;
        for (int i = 0; i < nb; i++) p ^= val[i];
        seq[0] = 1'b0;
        for (int i = 0; i < nb; i++) seq[1+i] = msb ? val[nb-1-i] : val[i];
        seq[nb+1] = (par < 0) ? p : par[0];
        seq[nb+2] = stopb;
        for (int b = first; b <= last; b++) begin
            ps2d = seq[b];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (pop_at_stop && b == nb + 2) begin
                    if (k == 2) begin
                        if (sb.size() == 0) check("sb_empty_pop", 1, 0);
                        else check("head_before_pop", m_dout, sb.pop_front());
                        rd_en = 1'b1;
                    end else if (k == 3) begin
                        rd_en = 1'b0;
                    end
                end
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_good(input logic [8:0] val, input int nb, input bit msb);
        sb.push_back(val);
        send_frame(val, nb, msb, -1, 1'b1, 0, nb + 2, 1'b0);
        idle(HALF);
    endtask

    task automatic read_check(input string tag);
        check({tag, "_valid"}, m_valid, 1);
        if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check({tag, "_data"}, m_dout, sb.pop_front());
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_k;
        ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0; clear_err = 1'b0; sel = 0; rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);

        check("rst_dout", m_dout, 0);
        check("rst_valid", m_valid, 0);
        check("rst_count", m_count, 0);
        check("rst_flags", m_flags, 0);

        // Single good frame then pop
        send_good(9'h0B2, 8, 1'b0);
        check("t1_count", m_count, 1);
        check("t1_flags", m_flags, 0);
        read_check("t1");
        check("t1_empty_valid", m_valid, 0);
        check("t1_empty_dout", m_dout, 0);
        check("t1_empty_count", m_count, 0);

        // Parity error, clear, framing error
        send_frame(9'h0B2, 8, 1'b0, 0, 1'b1, 0, 10, 1'b0);
        idle(HALF);
        check("t2_perr_flags", m_flags, 3'b100);
        check("t2_perr_count", m_count, 0);
        pulse_clear();
        check("t2_cleared", m_flags, 0);
        send_frame(9'h01C, 8, 1'b0, -1, 1'b0, 0, 10, 1'b0);
        idle(HALF);
        check("t2_ferr_flags", m_flags, 3'b010);
        check("t2_ferr_count", m_count, 0);
        pulse_clear();

        // Overflow, then simultaneous push/pop while full
        for (int v = 1; v <= 4; v++) send_good(9'(v), 8, 1'b0);
        check("t3_full_count", m_count, 4);
        send_frame(9'h005, 8, 1'b0, -1, 1'b1, 0, 10, 1'b0);
        idle(HALF);
        check("t3_ovf_flags", m_flags, 3'b001);
        check("t3_ovf_count", m_count, 4);
        for (int v = 1; v <= 4; v++) read_check("t3_drain");
        check("t3_drained", m_count, 0);
        pulse_clear();
        for (int v = 1; v <= 4; v++) send_good(9'(v), 8, 1'b0);
        sb.push_back(9'h005);
        send_frame(9'h005, 8, 1'b0, -1, 1'b1, 0, 10, 1'b1);
        idle(HALF);
        check("t3_pp_flags", m_flags, 0);
        check("t3_pp_count", m_count, 4);
        for (int v = 0; v < 4; v++) read_check("t3_pp_drain");
        check("t3_pp_empty", m_valid, 0);

        // Inter-bit timeout
        sel = 1;
        idle(2);
        send_frame(9'h05A, 8, 1'b0, -1, 1'b1, 0, 3, 1'b0);
        first_k = -1;
        for (int k = HALF + 1; k <= 130; k++) begin
            @(negedge clk);
            if (first_k < 0 && m_flags[1]) first_k = k;
        end
        check("t4_timeout_seen", (first_k >= 101 && first_k <= 106), 1);
        check("t4_flags", m_flags, 3'b010);
        check("t4_count", m_count, 0);
        pulse_clear();
        check("t4_cleared", m_flags, 0);
        send_good(9'h05A, 8, 1'b0);
        check("t4_after_flags", m_flags, 0);
        read_check("t4_after");

        // MSB-first and 9-bit instances
        sel = 2;
        idle(2);
        send_good(9'h0B2, 8, 1'b1);
        check("t5_msb_flags", m_flags, 0);
        read_check("t5_msb");
        sel = 3;
        idle(2);
        send_good(9'h1A5, 9, 1'b0);
        check("t5_9b_flags", m_flags, 0);
        read_check("t5_9b");

        // Reset mid-frame
        sel = 0;
        idle(2);
        send_good(9'h033, 8, 1'b0);
        send_frame(9'h0B2, 8, 1'b0, 0, 1'b1, 0, 10, 1'b0);
        idle(HALF);
        check("t6_pre_count", m_count, 1);
        check("t6_pre_flags", m_flags, 3'b100);
        send_frame(9'h0C3, 8, 1'b0, -1, 1'b1, 0, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("t6_rst_dout", m_dout, 0);
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_count", m_count, 0);
        check("t6_rst_flags", m_flags, 0);
        send_frame(9'h0C3, 8, 1'b0, -1, 1'b1, 7, 10, 1'b0);
        idle(HALF);
        check("t6_tail_flags", m_flags, 0);
        check("t6_tail_count", m_count, 0);
        send_good(9'h0F0, 8, 1'b0);
        check("t6_f0_count", m_count, 1);
        read_check("t6_f0");
        check("t6_final_count", m_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver, successor to the fixed 8-bit PS2Interface. It runs entirely in the system `clk` domain and oversamples the raw `ps2_clk`/`ps2_data` lines through synchronisers. Each 11-bit frame (start, data, odd parity, stop) is checked for parity, framing and inter-bit timeout. Good frames are queued in a first-word-fall-through FIFO that the keyboard/scan-code logic drains.

## Interface
- `DATA_BITS`, 8, payload bits per frame.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2, synchroniser flops on each PS/2 input; ≥2.
- `TIMEOUT_CYCLES`, 50000, max `clk` cycles between falling PS/2 edges inside a frame.
- `MSB_FIRST`, 0, 0 = first data bit is LSB (standard PS/2); 1 = first data bit is MSB.
- `clk` in 1: system clock; one clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock line, asynchronous.
- `ps2_data` in 1: raw PS/2 data line, asynchronous.
- `rd_en` in 1: pop the FIFO head; ignored when `valid`=0.
- `clear_err` in 1: clears all sticky error flags.
- `data_out` out DATA_BITS: FIFO head; forced 0 when `valid`=0.
- `valid` out 1: FIFO non-empty.
- `count` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `parity_err` out 1: sticky; a frame failed the odd-parity check.
- `frame_err` out 1: sticky; start/stop violation or timeout.
- `overflow` out 1: sticky; a good frame was dropped because the FIFO was full.

## Operation
- `ps2_clk` and `ps2_data` each pass through `SYNC_STAGES` flops of equal depth, so they stay aligned. `fall` = synced clk is 0 and its previous registered value is 1. Data is sampled from synced data in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on `fall`, except timeout.
  - IDLE: sampled bit 0 → DATA, bit counter cleared. Sampled bit 1 → stay in IDLE (glitch/idle edge ignored).
  - DATA: shift the bit in per `MSB_FIRST`. After the `DATA_BITS`-th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: evaluate the frame, then → IDLE.
- Frame evaluation in the STOP `fall` cycle:
  - stop bit = 0 → set `frame_err`, discard.
  - else XOR(data, parity) = 0 → set `parity_err`, discard.
  - else FIFO full and no pop this cycle → set `overflow`, discard.
  - else push.
- Timeout: a counter resets to 0 on every `fall` and in IDLE, and increments otherwise. When it reaches `TIMEOUT_CYCLES` in any state other than IDLE: → IDLE, partial frame discarded, set `frame_err`.
- FIFO: circular buffer whose read/write pointers wrap at `FIFO_DEPTH`.
  - Pop when `rd_en` & `valid`.
  - Push and pop in the same cycle are both performed, including when full (no overflow) and when `count`=1.
  - `count` is unchanged when a push and a pop coincide.
- Flags: set has priority over `clear_err` in the same cycle.
- Reset:
  - All outputs 0, FIFO empty, FSM in IDLE, counters 0.
  - Reset mid-frame abandons the frame silently: no push, no flag.

## Timing
- A raw `ps2_clk` fall reaches `fall` after `SYNC_STAGES`+1 rising `clk` edges, ±1 cycle of sampling uncertainty.
- Push latency: `valid`/`count`/`data_out` update on the edge ending the STOP `fall` cycle, i.e. the first cycle after it.
- Pop latency: after a pop, the next head (or `valid`=0) is visible in the following cycle.
- Flags assert in the cycle after the offending `fall` or timeout cycle.
- PS/2 line requirement: the line's low and high phases must each exceed `SYNC_STAGES`+1 `clk` cycles.

## Test plan
1. Send 0xB2 LSB-first with parity 1 and stop 1, PS/2 half-period 10 clk, default parameters → `valid`=1, `data_out`=0xB2, `count`=1, no flags. Pulse `rd_en` → `valid`=0, `data_out`=0, `count`=0.
2. Send 0xB2 with parity 0 → no push, `parity_err`=1. Pulse `clear_err` → 0. Send 0x1C with stop bit 0 → `frame_err`=1, `count`=0.
3. Send 0x01–0x04 without reading, then 0x05 → `overflow`=1, `count`=4, reads return 01, 02, 03, 04. Refill to 4, then hold `rd_en` in the same cycle as 0x05's STOP `fall` → no overflow, `count`=4, last entry 0x05.
4. `TIMEOUT_CYCLES`=100: stop `ps2_clk` after start + 3 data bits → `frame_err`=1 within 100–102 clk of the last fall, FSM in IDLE. A following good 0x5A → `data_out`=0x5A.
5. `MSB_FIRST`=1, `DATA_BITS`=8: send bits 1,0,1,1,0,0,1,0 with parity 1 and stop 1 → `data_out`=0xB2. `DATA_BITS`=9 instance: 0x1A5 with parity 0 → `data_out`=0x1A5.
6. Assert `rst` for 1 cycle after 6 data bits → all outputs 0. The remaining edges of the broken frame raise no flags and push nothing (a 1 in IDLE is ignored; a 0 starts a frame that later errors only as a timeout or framing error, which the bench records as expected). A subsequent clean 0xF0 → `data_out`=0xF0.
